// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit pipeline.
// Holds the instruction encoding constants and the fetch FSM state type.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR  = 16'hE000;
    localparam logic [3:0]  HLT_OPCODE = 4'hF;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = HLT_OPCODE;

    typedef enum logic [2:0] {
        StBoot    = 3'd0,
        StReq     = 3'd1,
        StHold    = 3'd2,
        StDiscard = 3'd3,
        StHalt    = 3'd4
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for an instruction and its address.
// Covers the cycles where decode stalls after memory has already answered.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        valid
);

    logic [15:0] instr_q;
    logic [15:0] pc_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            // A clear wins so a redirect can never leave a stale entry behind.
            if (clear) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
                instr_q <= load_instr;
                pc_q    <= load_pc;
            end
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding request to a variable-latency memory,
// a one-entry stall buffer, wrong-path squashing and a halt park state.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
    parameter logic [3:0]  HLT_OPCODE = cpu_pkg::HLT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branching,
    input  logic [15:0] next_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        flush,
    output logic        halted
);
    import cpu_pkg::*;

    fetch_state_e state_q, state_d;
    logic [15:0]  req_addr_q, req_addr_d;
    // Redirect target parked while a squashed request is still in flight.
    logic [15:0]  tgt_addr_q, tgt_addr_d;

    logic        buf_load;
    logic        buf_clear;
    logic        buf_valid;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc;

    logic        mem_offer;
    logic        offer_valid;
    logic [15:0] offer_instr;
    logic [15:0] req_addr_plus2;
    logic [15:0] buf_pc_plus2;
    logic        mem_is_hlt;
    logic        buf_is_hlt;
    logic        outstanding;

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_data),
        .load_pc    (req_addr_q),
        .instr      (buf_instr),
        .pc         (buf_pc),
        .valid      (buf_valid)
    );

    assign req_addr_plus2 = req_addr_q + 16'd2;
    assign buf_pc_plus2   = buf_pc + 16'd2;

    // Memory data goes straight to decode in its response cycle; DISCARD never offers.
    assign mem_offer   = (state_q == StReq) && imem_valid;
    assign offer_valid = buf_valid || mem_offer;
    assign offer_instr = buf_valid ? buf_instr : imem_data;

    assign mem_is_hlt  = (opcode_of(imem_data) == HLT_OPCODE);
    assign buf_is_hlt  = (opcode_of(buf_instr) == HLT_OPCODE);
    assign outstanding = ((state_q == StReq) || (state_q == StDiscard)) && !imem_valid;

    assign imem_req    = (state_q == StReq) || (state_q == StDiscard);
    assign imem_addr   = req_addr_q;
    assign instruction = offer_valid ? offer_instr : NOP_INSTR;
    assign pc_plus2    = buf_valid ? buf_pc_plus2 : req_addr_plus2;
    assign flush       = branching;
    assign halted      = (state_q == StHalt);

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        tgt_addr_d = tgt_addr_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StReq;
            end
            StReq: begin
                if (imem_valid) begin
                    if (stall) begin
                        buf_load = 1'b1;
                        state_d  = StHold;
                    end else begin
                        req_addr_d = req_addr_plus2;
                        state_d    = mem_is_hlt ? StHalt : StReq;
                    end
                end
            end
            StHold: begin
                if (!stall) begin
                    buf_clear  = 1'b1;
                    req_addr_d = buf_pc_plus2;
                    state_d    = buf_is_hlt ? StHalt : StReq;
                end
            end
            StDiscard: begin
                if (imem_valid) begin
                    req_addr_d = tgt_addr_q;
                    state_d    = StReq;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        // A redirect overrides everything; imem_addr must stay put while a request is open.
        if (branching) begin
            buf_load  = 1'b0;
            buf_clear = 1'b1;
            if (outstanding) begin
                req_addr_d = req_addr_q;
                tgt_addr_d = next_pc;
                state_d    = StDiscard;
            end else begin
                req_addr_d = next_pc;
                state_d    = StReq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            req_addr_q <= RESET_PC;
            tgt_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            tgt_addr_q <= tgt_addr_d;
        end
    end

    addr_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req && !imem_valid) |=> $stable(imem_addr));

    buf_only_in_hold_a : assert property (@(posedge clk) disable iff (!rst_n)
        buf_valid |-> (state_q == StHold));

endmodule
